// File: rtl/prbs_gen_param.sv
// -----------------------------------------------------------------------------
// prbs_gen_param
//   Parametrised PRBS pattern generator for the BERT transmit path. It replaces
//   the fixed PRBS-13 source and stays bit-compatible with it in mode 2.
//   The polynomial can be selected at runtime (PRBS7/9/13/15/23/31). The block
//   produces DATA_W bits per enabled clock, supports seed loading, and escapes
//   the all-zero lock-up state.
//
// Parameters
//   DATA_W      bits produced per enabled clock (1..32)
//   SEED        state loaded at reset and on a mode change, masked to L(mode)
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous, active-high
//   control     in   1       1 = advance the generator this cycle, 0 = hold
//   mode        in   3       0:PRBS7 1:PRBS9 2:PRBS13 3:PRBS15 4:PRBS23 5:PRBS31
//                            6,7: illegal
//   load_seed   in   1       1-cycle pulse: load seed_in (masked) into state
//   seed_in     in   31      seed value
//   inject_err  in   1       error-injection request
//   data_out    out  DATA_W  pattern word, MSB = first bit in time
//   data_valid  out  1       data_out holds a new word this cycle
//   mode_err    out  1       the mode seen on the previous clock was illegal
//   lfsr_state  out  31      current state; bits above L-1 are always 0
//
// Build option
//   PRBS_ERR_INJ_EN  When defined, an inject_err pulse arms a pending flag.
//                    The next valid word then leaves with its MSB inverted.
//                    lfsr_state is never touched by this. When the macro is
//                    undefined, inject_err is ignored.
// -----------------------------------------------------------------------------
module prbs_gen_param #(
  parameter int          DATA_W = 8,
  parameter logic [30:0] SEED   = 31'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              control,
  input  logic [2:0]        mode,
  input  logic              load_seed,
  input  logic [30:0]       seed_in,
  input  logic              inject_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              mode_err,
  output logic [30:0]       lfsr_state
);

  // ---------------------------------------------------------------------------
  // Polynomial helpers
  // ---------------------------------------------------------------------------

  function automatic logic mode_illegal(input logic [2:0] m);
    return (m > 3'd5);
  endfunction

  // Ones in the low L bits for the selected length. Illegal modes return 0.
  function automatic logic [30:0] len_mask(input logic [2:0] m);
    logic [30:0] r;
    case (m)
      3'd0:    r = 31'h0000_007F;
      3'd1:    r = 31'h0000_01FF;
      3'd2:    r = 31'h0000_1FFF;
      3'd3:    r = 31'h0000_7FFF;
      3'd4:    r = 31'h007F_FFFF;
      3'd5:    r = 31'h7FFF_FFFF;
      default: r = 31'h0000_0000;
    endcase
    return r;
  endfunction

  // Bit shifted out on this step: s[L-1].
  function automatic logic msb_of(input logic [30:0] s, input logic [2:0] m);
    logic r;
    case (m)
      3'd0:    r = s[6];
      3'd1:    r = s[8];
      3'd2:    r = s[12];
      3'd3:    r = s[14];
      3'd4:    r = s[22];
      3'd5:    r = s[30];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // One Fibonacci step: shift left, feed the tap XOR into bit 0, then clip
  // to L bits. The PRBS13 taps match the legacy fixed generator.
  function automatic logic [30:0] step_of(input logic [30:0] s, input logic [2:0] m);
    logic fb;
    case (m)
      3'd0:    fb = s[6]  ^ s[5];
      3'd1:    fb = s[8]  ^ s[4];
      3'd2:    fb = s[12] ^ s[3] ^ s[2] ^ s[0];
      3'd3:    fb = s[14] ^ s[13];
      3'd4:    fb = s[22] ^ s[17];
      3'd5:    fb = s[30] ^ s[27];
      default: fb = 1'b0;
    endcase
    return {s[29:0], fb} & len_mask(m);
  endfunction

  // Value written into the state on any load. An all-zero pattern would
  // lock the LFSR up, so 1 is loaded in its place. In an illegal mode there
  // is no length, and the state is parked at 0.
  function automatic logic [30:0] load_value(input logic [30:0] v, input logic [2:0] m);
    logic [30:0] masked;
    masked = v & len_mask(m);
    if (mode_illegal(m))
      return 31'h0;
    else if (masked == 31'h0)
      return 31'h1;
    else
      return masked;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [30:0]       state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              mode_err_q, mode_err_d;

`ifdef PRBS_ERR_INJ_EN
  logic              pend_q, pend_d;
`else
  // The request input has no function in this build.
  logic              unused_inject;
  assign unused_inject = inject_err;
`endif

  logic [DATA_W-1:0] word_c;
  logic [30:0]       next_c;

  // ---------------------------------------------------------------------------
  // DATA_W steps unrolled in one cycle. The first bit generated lands in the
  // word MSB, so the word is already in transmit order for the serialiser.
  // ---------------------------------------------------------------------------
  always_comb begin : unroll
    logic [30:0] walk;
    walk   = state_q;
    word_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      word_c[DATA_W-1-i] = msb_of(walk, mode_q);
      walk               = step_of(walk, mode_q);
    end
    next_c = walk;
  end

  // ---------------------------------------------------------------------------
  // Per-cycle actions, in priority order: load_seed, then a mode change, then
  // an enabled advance, otherwise hold. Reset is applied in the register
  // block. A load_seed that collides with a mode change defers the change by
  // one cycle, because mode_q is not updated on that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    mode_err_d = mode_illegal(mode);
`ifdef PRBS_ERR_INJ_EN
    // A pulse that arrives while a request is already pending is absorbed.
    pend_d     = pend_q | inject_err;
`endif

    if (load_seed) begin
      if (!mode_illegal(mode_q))
        state_d = load_value(seed_in, mode_q);
    end else if (mode != mode_q) begin
      // Restart: no word is produced this cycle. Entering an illegal mode
      // freezes the state where it is.
      mode_d = mode;
      if (!mode_illegal(mode))
        state_d = load_value(SEED, mode);
`ifdef PRBS_ERR_INJ_EN
      pend_d = 1'b0;
`endif
    end else if (control && !mode_illegal(mode_q)) begin
      state_d = next_c;
      data_d  = word_c;
      valid_d = 1'b1;
`ifdef PRBS_ERR_INJ_EN
      // The corruption is applied to the output word only. The LFSR keeps
      // the clean sequence, so the RX checker can re-sync.
      data_d[DATA_W-1] = word_c[DATA_W-1] ^ pend_q;
      if (pend_q)
        pend_d = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= load_value(SEED, mode);
      mode_q     <= mode;
      data_q     <= '0;
      valid_q    <= 1'b0;
      mode_err_q <= 1'b0;
`ifdef PRBS_ERR_INJ_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      mode_err_q <= mode_err_d;
`ifdef PRBS_ERR_INJ_EN
      pend_q     <= pend_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign mode_err   = mode_err_q;
  assign lfsr_state = state_q;

endmodule

// File: tb/tb_prbs_gen_param.sv
// -----------------------------------------------------------------------------
// tb_prbs_gen_param
//   Bench for prbs_gen_param. Two instances share the same stimulus: one with
//   DATA_W=1 and one with DATA_W=8. A table of hand-computed vectors covers
//   reset, the first words, hold, seed loading, the lock-up escape, illegal
//   mode, and the restart. Hand-written sequences then check the PRBS7 period,
//   every polynomial while control toggles, and error injection. Those
//   sequences compare against a tap-mask reference model.
// -----------------------------------------------------------------------------
module tb_prbs_gen_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, control, load_seed, inject_err;
  logic [2:0]  mode;
  logic [30:0] seed_in;

  logic [0:0]  d1;
  logic        v1, e1;
  logic [30:0] s1;
  logic [7:0]  d8;
  logic        v8, e8;
  logic [30:0] s8;

  prbs_gen_param #(.DATA_W(1), .SEED(31'hF)) u1 (
    .clock(clock), .reset(reset), .control(control), .mode(mode),
    .load_seed(load_seed), .seed_in(seed_in), .inject_err(inject_err),
    .data_out(d1), .data_valid(v1), .mode_err(e1), .lfsr_state(s1)
  );

  prbs_gen_param #(.DATA_W(8), .SEED(31'hF)) u8 (
    .clock(clock), .reset(reset), .control(control), .mode(mode),
    .load_seed(load_seed), .seed_in(seed_in), .inject_err(inject_err),
    .data_out(d8), .data_valid(v8), .mode_err(e8), .lfsr_state(s8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [30:0] gs1, gs8;
  logic        gd1;
  logic [7:0]  gd8;

  typedef struct {
    logic        rst, ctl, ld;
    logic [2:0]  md;
    logic [30:0] seed;
    logic [30:0] xs1;
    logic        xd1;
    logic [30:0] xs8;
    logic [7:0]  xd8;
    logic        xv, xe;
  } vec_t;

  vec_t vt [12];

  function automatic int g_len(input logic [2:0] m);
    case (m)
      3'd0: return 7;
      3'd1: return 9;
      3'd2: return 13;
      3'd3: return 15;
      3'd4: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic logic [30:0] g_taps(input logic [2:0] m);
    case (m)
      3'd0: return 31'h0000_0060;
      3'd1: return 31'h0000_0110;
      3'd2: return 31'h0000_100D;
      3'd3: return 31'h0000_6000;
      3'd4: return 31'h0042_0000;
      default: return 31'h4800_0000;
    endcase
  endfunction

  // Returns {out_bit, next_state}.
  function automatic logic [31:0] g_step(input logic [30:0] s, input logic [2:0] m);
    int          L;
    logic [30:0] msk;
    logic        fb;
    L   = g_len(m);
    msk = 31'h7FFF_FFFF >> (31 - L);
    fb  = ^(s & g_taps(m));
    return {s[L-1], ((s << 1) | {30'b0, fb}) & msk};
  endfunction

  task automatic g_adv(input logic [2:0] m);
    logic [31:0] r;
    r   = g_step(gs1, m);
    gd1 = r[31];
    gs1 = r[30:0];
    for (int i = 0; i < 8; i++) begin
      r         = g_step(gs8, m);
      gd8[7-i]  = r[31];
      gs8       = r[30:0];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic xv, input logic xe);
    chk({tag, "/s1"}, 32'(s1), 32'(gs1));
    chk({tag, "/s8"}, 32'(s8), 32'(gs8));
    chk({tag, "/d1"}, 32'(d1), 32'(gd1));
    chk({tag, "/d8"}, 32'(d8), 32'(gd8));
    chk({tag, "/v1"}, 32'(v1), 32'(xv));
    chk({tag, "/v8"}, 32'(v8), 32'(xv));
    chk({tag, "/err"}, 32'(e1), 32'(xe));
  endtask

  // Called at a falling edge: drive the inputs, let one rising edge pass,
  // and return at the next falling edge so that outputs are sampled mid-cycle.
  task automatic drive(input logic rst, input logic ctl, input logic ld,
                       input logic [2:0] md, input logic [30:0] sd, input logic inj);
    reset      = rst;
    control    = ctl;
    load_seed  = ld;
    mode       = md;
    seed_in    = sd;
    inject_err = inj;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic       early;
    logic [2:0] md;
    logic [5:0] pat;
    logic       xd1;
    logic [7:0] xd8;

    reset = 1'b1; control = 1'b0; load_seed = 1'b0; inject_err = 1'b0;
    mode = 3'd2; seed_in = 31'h0;

    //          rst   ctl   ld    md    seed          xs1           xd1   xs8           xd8    xv    xe
    vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd2, 31'h0,        31'hF,        1'b0, 31'hF,        8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 3'd2, 31'h0,        31'h1F,       1'b0, 31'hFFF,      8'h00, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 31'h0,        31'h3F,       1'b0, 31'h1FA1,     8'h7F, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 31'h0,        31'h3F,       1'b0, 31'h1FA1,     8'h7F, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 3'd2, 31'h0,        31'h1,        1'b0, 31'h1,        8'h7F, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 3'd2, 31'h0,        31'h3,        1'b0, 31'h1C7,      8'h00, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 3'd6, 31'h0,        31'h3,        1'b0, 31'h1C7,      8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 3'd6, 31'h0,        31'h3,        1'b0, 31'h1C7,      8'h00, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 3'd5, 31'h0,        31'hF,        1'b0, 31'hF,        8'h00, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 3'd5, 31'h0,        31'h1E,       1'b0, 31'hF00,      8'h00, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 3'd5, 31'h4000_0000, 31'h4000_0000, 1'b0, 31'h4000_0000, 8'h00, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 31'h0,        31'h1,        1'b1, 31'h80,       8'h80, 1'b1, 1'b0};

    @(negedge clock);

    // Directed table
    for (int k = 0; k < 12; k++) begin
      drive(vt[k].rst, vt[k].ctl, vt[k].ld, vt[k].md, vt[k].seed, 1'b0);
      chk($sformatf("vec%0d/s1", k),  32'(s1), 32'(vt[k].xs1));
      chk($sformatf("vec%0d/d1", k),  32'(d1), 32'(vt[k].xd1));
      chk($sformatf("vec%0d/s8", k),  32'(s8), 32'(vt[k].xs8));
      chk($sformatf("vec%0d/d8", k),  32'(d8), 32'(vt[k].xd8));
      chk($sformatf("vec%0d/v1", k),  32'(v1), 32'(vt[k].xv));
      chk($sformatf("vec%0d/v8", k),  32'(v8), 32'(vt[k].xv));
      chk($sformatf("vec%0d/err", k), 32'(e1), 32'(vt[k].xe));
      chk($sformatf("vec%0d/err8", k), 32'(e8), 32'(vt[k].xe));
    end

    // PRBS7 period: seed 1 must come back after exactly 127 steps
    drive(1'b1, 1'b0, 1'b0, 3'd0, 31'h0, 1'b0);
    gs1 = 31'hF; gs8 = 31'hF; gd1 = 1'b0; gd8 = 8'h00;
    chk_all("t3rst", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 31'h1, 1'b0);
    gs1 = 31'h1; gs8 = 31'h1;
    chk_all("t3ld", 1'b0, 1'b0);
    early = 1'b0;
    for (int c = 1; c <= 127; c++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd0, 31'h0, 1'b0);
      g_adv(3'd0);
      if (c < 127 && s1 == 31'h1) early = 1'b1;
      chk($sformatf("t3c%0d/s1", c), 32'(s1), 32'(gs1));
      chk($sformatf("t3c%0d/s8", c), 32'(s8), 32'(gs8));
      chk($sformatf("t3c%0d/d8", c), 32'(d8), 32'(gd8));
    end
    chk("t3_early_return", 32'(early), 32'd0);
    chk("t3_wrap", 32'(s1), 32'h1);

    // Every polynomial: restart on the mode change, then control 1,0,0,1,1,1
    pat = 6'b100111;
    for (int m = 1; m <= 6; m++) begin
      md = 3'(m % 6);
      drive(1'b0, 1'b1, 1'b0, md, 31'h0, 1'b0);
      gs1 = 31'hF; gs8 = 31'hF;
      chk_all($sformatf("t5m%0d/restart", md), 1'b0, 1'b0);
      for (int j = 0; j < 6; j++) begin
        drive(1'b0, pat[5-j], 1'b0, md, 31'h0, 1'b0);
        if (pat[5-j]) g_adv(md);
        chk_all($sformatf("t5m%0d/c%0d", md, j), pat[5-j], 1'b0);
      end
    end

    // Error injection, in mode 0: two pulses while idle, then two words
    drive(1'b0, 1'b0, 1'b0, 3'd0, 31'h0, 1'b1);
    chk_all("t6idle1", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 31'h0, 1'b1);
    chk_all("t6idle2", 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 31'h0, 1'b0);
    g_adv(3'd0);
`ifdef PRBS_ERR_INJ_EN
    xd1 = ~gd1;
    xd8 = gd8 ^ 8'h80;
`else
    xd1 = gd1;
    xd8 = gd8;
`endif
    chk("t6w1/s1", 32'(s1), 32'(gs1));
    chk("t6w1/s8", 32'(s8), 32'(gs8));
    chk("t6w1/d1", 32'(d1), 32'(xd1));
    chk("t6w1/d8", 32'(d8), 32'(xd8));
    chk("t6w1/v8", 32'(v8), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 31'h0, 1'b0);
    g_adv(3'd0);
    chk_all("t6w2", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
